// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg
//   Shared constants for the SPI slave: default frame width, default
//   synchronizer depth and the FSM state encoding.
package spi_slave_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage : spi_slave_pkg

// File: rtl/spi_slave_if.sv
// spi_slave_if
//   Bundles the SPI pins and the parallel byte handshake of the SPI slave.
//   Ports (by modport):
//     slave  : in  spi_sclk, spi_cs, spi_mosi, data_send
//              out spi_miso, data_rec, rec_done, send_req, busy
//     master : the same signals with directions reversed
interface spi_slave_if
    import spi_slave_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              spi_sclk;
    logic              spi_cs;
    logic              spi_mosi;
    logic              spi_miso;
    logic [DATA_W-1:0] data_send;
    logic [DATA_W-1:0] data_rec;
    logic              rec_done;
    logic              send_req;
    logic              busy;

    modport slave (
        input  spi_sclk, spi_cs, spi_mosi, data_send,
        output spi_miso, data_rec, rec_done, send_req, busy
    );

    modport master (
        output spi_sclk, spi_cs, spi_mosi, data_send,
        input  spi_miso, data_rec, rec_done, send_req, busy
    );

endinterface : spi_slave_if

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Synchronizes one asynchronous input into sys_clk and produces
//   single-cycle rise/fall pulses from the synchronized value.
//   Ports:
//     sys_clk, sys_rst_n : clock, async active-low reset
//     din                : asynchronous input
//     rise, fall         : one-cycle pulses on synchronized edges
//   RST_VAL is the value the whole chain resets to, so that an input
//   idling at that level produces no spurious edge after reset.
module spi_sync_edge
    import spi_slave_pkg::*;
#(
    parameter int   STAGES  = SYNC_STAGES_DEF,
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = din;
        prev_d    = sync_q[STAGES-1];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise =  sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] &  prev_q;

endmodule : spi_sync_edge

// File: rtl/spi_slave.sv
// spi_slave
//   SPI mode 0 slave, MSB first, oversampled on sys_clk. All SPI pins are
//   synchronized; sclk and cs are edge-detected, mosi is sampled from its
//   synchronizer on sclk rising edges.
//   Ports:
//     sys_clk, sys_rst_n : clock, async active-low reset
//     bus (slave)        : SPI pins plus data_send / data_rec / rec_done /
//                          send_req / busy
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | cs high; sclk ignored, miso held 0
//   ST_ACTIVE | cs low; shift on sclk edges, busy high
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    spi_slave_if.slave bus
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .din       (bus.spi_sclk),
        .rise      (sclk_rise),
        .fall      (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .din       (bus.spi_cs),
        .rise      (cs_rise),
        .fall      (cs_fall)
    );

    // mosi needs no edge detection, only a plain synchronizer chain whose
    // depth matches sclk so the sampled bit lines up with the rise pulse.
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   mosi_s;

    always_comb begin
        mosi_sync_d    = mosi_sync_q << 1;
        mosi_sync_d[0] = bus.spi_mosi;
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    // Holds the first DATA_W-1 bits; the last bit is taken straight from
    // mosi when the byte completes.
    logic [DATA_W-2:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] data_rec_q, data_rec_d;
    logic              rec_done_q, rec_done_d;
    logic              send_req_q, send_req_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        data_rec_d = data_rec_q;
        rec_done_d = 1'b0;
        send_req_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    tx_d      = bus.data_send;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                end
            end
            ST_ACTIVE: begin
                // cs release wins over any sclk edge in the same cycle.
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                end else if (sclk_rise) begin
                    rx_d = {rx_q[DATA_W-3:0], mosi_s};
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d  = '0;
                        data_rec_d = {rx_q, mosi_s};
                        rec_done_d = 1'b1;
                        send_req_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    // Counter at 0 on a falling edge means a byte boundary:
                    // the next byte is picked up here.
                    if (bit_cnt_q == '0) begin
                        tx_d = bus.data_send;
                    end else begin
                        tx_d = tx_q << 1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mosi_sync_q <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            data_rec_q  <= '0;
            rec_done_q  <= 1'b0;
            send_req_q  <= 1'b0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            data_rec_q  <= data_rec_d;
            rec_done_q  <= rec_done_d;
            send_req_q  <= send_req_d;
        end
    end

    assign bus.spi_miso = (state_q == ST_ACTIVE) & tx_q[DATA_W-1];
    assign bus.data_rec = data_rec_q;
    assign bus.rec_done = rec_done_q;
    assign bus.send_req = send_req_q;
    assign bus.busy     = (state_q == ST_ACTIVE);

endmodule : spi_slave

// File: tb/tb_spi_slave.sv
// tb_spi_slave
//   Directed bench for spi_slave: acts as a mode 0 SPI master with
//   sclk = sys_clk/8 and checks received bytes, pulses and idle behaviour.
module tb_spi_slave;

    logic sys_clk;
    logic sys_rst_n;

    spi_slave_if #(.DATA_W(8)) bus ();

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    int         rec_cnt  = 0;
    int         sreq_cnt = 0;
    logic [7:0] rec_hist[$];

    always @(negedge sys_clk) begin
        if (bus.rec_done === 1'b1) begin
            rec_cnt++;
            rec_hist.push_back(bus.data_rec);
        end
        if (bus.send_req === 1'b1) sreq_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cs_low();
        @(negedge sys_clk);
        bus.spi_cs = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic cs_high();
        repeat (2) @(negedge sys_clk);
        bus.spi_cs = 1'b1;
        repeat (8) @(negedge sys_clk);
    endtask

    // Shifts the top nbits of tx out MSB first, sampling miso on each
    // rising edge. Half period is 4 sys_clk cycles.
    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.spi_mosi = tx[i];
            repeat (4) @(negedge sys_clk);
            bus.spi_sclk = 1'b1;
            rx[i] = bus.spi_miso;
            repeat (4) @(negedge sys_clk);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        sys_rst_n     = 1'b0;
        bus.spi_sclk  = 1'b0;
        bus.spi_cs    = 1'b1;
        bus.spi_mosi  = 1'b0;
        bus.data_send = 8'h00;
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.spi_miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", bus.spi_miso); else n_pass++;
        n_checks++; if (bus.data_rec !== 8'h00) $display("FAIL reset_data_rec: got %h want 00", bus.data_rec); else n_pass++;
        n_checks++; if (bus.rec_done !== 1'b0) $display("FAIL reset_rec_done: got %b want 0", bus.rec_done); else n_pass++;
        n_checks++; if (bus.send_req !== 1'b0) $display("FAIL reset_send_req: got %b want 0", bus.send_req); else n_pass++;
    endtask

    task automatic test_single();
        logic [7:0] rx;
        int r0, s0;
        r0 = rec_cnt; s0 = sreq_cnt;
        bus.data_send = 8'hA5;
        cs_low();
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy_active: got %b want 1", bus.busy); else n_pass++;
        spi_byte(8'h3C, 8, rx);
        cs_high();
        n_checks++; if (rx !== 8'hA5) $display("FAIL single_miso: got %h want a5", rx); else n_pass++;
        n_checks++; if (bus.data_rec !== 8'h3C) $display("FAIL single_data_rec: got %h want 3c", bus.data_rec); else n_pass++;
        n_checks++; if (rec_cnt - r0 !== 1) $display("FAIL single_rec_done_count: got %0d want 1", rec_cnt - r0); else n_pass++;
        n_checks++; if (sreq_cnt - s0 !== 1) $display("FAIL single_send_req_count: got %0d want 1", sreq_cnt - s0); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy_idle: got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_burst();
        logic [7:0] mo[3];
        logic [7:0] ms[3];
        logic [7:0] reply[3];
        logic [7:0] rx[3];
        int r0;
        mo = '{8'h01, 8'h02, 8'h03};
        ms = '{8'h00, 8'h10, 8'h20};
        reply = '{8'h10, 8'h20, 8'h30};
        r0 = rec_cnt;
        bus.data_send = 8'h00;
        cs_low();
        fork
            begin
                for (int b = 0; b < 3; b++) spi_byte(mo[b], 8, rx[b]);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    logic seen;
                    seen = 1'b0;
                    for (int c = 0; c < 200 && !seen; c++) begin
                        @(negedge sys_clk);
                        if (bus.send_req === 1'b1) seen = 1'b1;
                    end
                    n_checks++;
                    if (!seen) $display("FAIL burst_send_req_timeout: byte %0d got no pulse want pulse", k);
                    else begin
                        n_pass++;
                        bus.data_send = reply[k];
                    end
                end
            end
        join
        cs_high();
        for (int b = 0; b < 3; b++) begin
            n_checks++;
            if (rx[b] !== ms[b]) $display("FAIL burst_miso_%0d: got %h want %h", b, rx[b], ms[b]); else n_pass++;
        end
        n_checks++; if (rec_cnt - r0 !== 3) $display("FAIL burst_rec_done_count: got %0d want 3", rec_cnt - r0); else n_pass++;
        for (int b = 0; b < 3; b++) begin
            n_checks++;
            if (rec_hist.size() < r0 + b + 1) $display("FAIL burst_rec_%0d: got none want %h", b, mo[b]);
            else if (rec_hist[r0 + b] !== mo[b]) $display("FAIL burst_rec_%0d: got %h want %h", b, rec_hist[r0 + b], mo[b]);
            else n_pass++;
        end
    endtask

    task automatic test_partial();
        logic [7:0] rx;
        int r0, s0;
        r0 = rec_cnt; s0 = sreq_cnt;
        bus.data_send = 8'h77;
        cs_low();
        spi_byte(8'hC3, 5, rx);
        cs_high();
        n_checks++; if (rec_cnt - r0 !== 0) $display("FAIL partial_rec_done: got %0d want 0", rec_cnt - r0); else n_pass++;
        n_checks++; if (sreq_cnt - s0 !== 0) $display("FAIL partial_send_req: got %0d want 0", sreq_cnt - s0); else n_pass++;
        n_checks++; if (bus.data_rec !== 8'h03) $display("FAIL partial_data_rec_held: got %h want 03", bus.data_rec); else n_pass++;
        r0 = rec_cnt;
        cs_low();
        spi_byte(8'hFF, 8, rx);
        cs_high();
        n_checks++; if (bus.data_rec !== 8'hFF) $display("FAIL partial_next_frame: got %h want ff", bus.data_rec); else n_pass++;
        n_checks++; if (rx !== 8'h77) $display("FAIL partial_next_miso: got %h want 77", rx); else n_pass++;
        n_checks++; if (rec_cnt - r0 !== 1) $display("FAIL partial_next_count: got %0d want 1", rec_cnt - r0); else n_pass++;
    endtask

    task automatic test_idle_sclk();
        int r0, s0;
        logic busy_seen, miso_seen;
        r0 = rec_cnt; s0 = sreq_cnt;
        busy_seen = 1'b0; miso_seen = 1'b0;
        bus.data_send = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            bus.spi_mosi = 1'b1;
            repeat (4) begin
                @(negedge sys_clk);
                if (bus.busy !== 1'b0) busy_seen = 1'b1;
                if (bus.spi_miso !== 1'b0) miso_seen = 1'b1;
            end
            bus.spi_sclk = ~bus.spi_sclk;
        end
        bus.spi_sclk = 1'b0;
        repeat (8) @(negedge sys_clk);
        n_checks++; if (busy_seen !== 1'b0) $display("FAIL idle_busy: got 1 want 0"); else n_pass++;
        n_checks++; if (miso_seen !== 1'b0) $display("FAIL idle_miso: got 1 want 0"); else n_pass++;
        n_checks++; if (rec_cnt - r0 !== 0) $display("FAIL idle_rec_done: got %0d want 0", rec_cnt - r0); else n_pass++;
        n_checks++; if (sreq_cnt - s0 !== 0) $display("FAIL idle_send_req: got %0d want 0", sreq_cnt - s0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        int r0;
        bus.data_send = 8'h81;
        cs_low();
        spi_byte(8'hE7, 3, rx);
        bus.spi_mosi = 1'b0;
        repeat (4) @(negedge sys_clk);
        bus.spi_sclk = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst_n    = 1'b0;
        bus.spi_sclk = 1'b0;
        bus.spi_cs   = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.spi_miso !== 1'b0) $display("FAIL rstmid_miso: got %b want 0", bus.spi_miso); else n_pass++;
        n_checks++; if (bus.data_rec !== 8'h00) $display("FAIL rstmid_data_rec: got %h want 00", bus.data_rec); else n_pass++;
        n_checks++; if (bus.rec_done !== 1'b0) $display("FAIL rstmid_rec_done: got %b want 0", bus.rec_done); else n_pass++;
        n_checks++; if (bus.send_req !== 1'b0) $display("FAIL rstmid_send_req: got %b want 0", bus.send_req); else n_pass++;
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_wait_cs: got %b want 0", bus.busy); else n_pass++;
        r0 = rec_cnt;
        bus.data_send = 8'h96;
        cs_low();
        spi_byte(8'h5A, 8, rx);
        cs_high();
        n_checks++; if (bus.data_rec !== 8'h5A) $display("FAIL rstmid_next_frame: got %h want 5a", bus.data_rec); else n_pass++;
        n_checks++; if (rx !== 8'h96) $display("FAIL rstmid_next_miso: got %h want 96", rx); else n_pass++;
        n_checks++; if (rec_cnt - r0 !== 1) $display("FAIL rstmid_next_count: got %0d want 1", rec_cnt - r0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] rx0, rx1;
        int r0;
        r0 = rec_cnt;
        bus.data_send = 8'h9E;
        cs_low();
        spi_byte(8'h06, 8, rx0);
        repeat (2) @(negedge sys_clk);
        bus.spi_cs = 1'b1;
        bus.data_send = 8'h3B;
        repeat (4) @(negedge sys_clk);
        bus.spi_cs = 1'b0;
        repeat (4) @(negedge sys_clk);
        spi_byte(8'hC7, 8, rx1);
        cs_high();
        n_checks++; if (rec_cnt - r0 !== 2) $display("FAIL b2b_count: got %0d want 2", rec_cnt - r0); else n_pass++;
        n_checks++;
        if (rec_hist.size() < r0 + 2) $display("FAIL b2b_seq: got %0d entries want 2 more", rec_hist.size() - r0);
        else if (rec_hist[r0] !== 8'h06 || rec_hist[r0 + 1] !== 8'hC7)
            $display("FAIL b2b_seq: got %h,%h want 06,c7", rec_hist[r0], rec_hist[r0 + 1]);
        else n_pass++;
        n_checks++; if (rx0 !== 8'h9E) $display("FAIL b2b_miso0: got %h want 9e", rx0); else n_pass++;
        n_checks++; if (rx1 !== 8'h3B) $display("FAIL b2b_miso1: got %h want 3b", rx1); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_partial();
        test_idle_sclk();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_spi_slave
